stack_call_sequencer: RTL

- Control-side master for the register file's hardware stack port; turns one decoded stack/call instruction into a timed cycle sequence on the register-file control pins.
- Opcodes: PUSH, POP, CALL, RET. Tracks stack depth, detects overflow/underflow, and issues a PC redirect for CALL/RET.
- Sits between the instruction decoder (valid/ready handshake) and the register file (Reg_write_Control, PC_Store, PUSH_Stack, PULL_Stack, StackData).

---
 rtl/stack_pkg.sv | 33 +++
 rtl/stack_depth_ctr.sv | 40 ++++
 rtl/stack_call_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared opcodes, FSM state encoding and default register indices for the stack call sequencer.
package stack_pkg;

   localparam logic [1:0] OP_PUSH = 2'd0;
   localparam logic [1:0] OP_POP  = 2'd1;
   localparam logic [1:0] OP_CALL = 2'd2;
   localparam logic [1:0] OP_RET  = 2'd3;

   localparam int unsigned StateW = 4;

   localparam logic [StateW-1:0] StIdle  = 4'd0;
   localparam logic [StateW-1:0] StPush  = 4'd1;
   localparam logic [StateW-1:0] StPull  = 4'd2;
   localparam logic [StateW-1:0] StPopWb = 4'd3;
   localparam logic [StateW-1:0] StSave  = 4'd4;
   localparam logic [StateW-1:0] StCpush = 4'd5;
   localparam logic [StateW-1:0] StRetLd = 4'd6;
   localparam logic [StateW-1:0] StDone  = 4'd7;
   localparam logic [StateW-1:0] StErr   = 4'd8;
   localparam logic [StateW-1:0] StSpWb  = 4'd9;

   localparam int unsigned    RaRegDefault  = 31;
   localparam int unsigned    SpRegDefault  = 29;
   localparam logic [31:0]    SpBaseDefault = 32'h0000_0100;

   typedef struct packed {
      logic [1:0]  code;
      logic [4:0]  rsel;
      logic [31:0] pc;
      logic [31:0] target;
   } stack_op_t;

endpackage

// File: rtl/stack_depth_ctr.sv
// Saturating up/down entry counter with full/empty flags for the hardware stack.
module stack_depth_ctr #(
   parameter int unsigned MaxCount = 16,
   parameter int unsigned Width    = $clog2(MaxCount + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [Width-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [Width-1:0] MaxVal = Width'(MaxCount);

   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MaxVal)) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == MaxVal);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/stack_call_sequencer.sv
// Sequences PUSH/POP/CALL/RET into register-file stack control cycles.
// Define STACK_SP_MIRROR_EN to write the SP mirror register after each successful operation.
module stack_call_sequencer
   import stack_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 16,
   parameter int unsigned RA_REG      = RaRegDefault,
   parameter int unsigned SP_REG      = SpRegDefault,
   parameter logic [31:0] SP_BASE     = SpBaseDefault,
   parameter int unsigned DepthW      = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              op_valid_i,
   output logic              op_ready_o,
   input  logic [1:0]        op_code_i,
   input  logic [4:0]        op_reg_i,
   input  logic [31:0]       pc_in_i,
   input  logic [31:0]       target_i,
   input  logic [31:0]       stack_data_i,
   output logic [4:0]        read_reg1_o,
   output logic [4:0]        write_reg_o,
   output logic [31:0]       write_data_o,
   output logic              reg_write_control_o,
   output logic              pc_store_o,
   output logic              push_stack_o,
   output logic              pull_stack_o,
   output logic              pc_load_o,
   output logic [31:0]       pc_next_o,
   output logic              done_o,
   output logic              err_o,
   output logic              err_sticky_o,
   output logic [DepthW-1:0] depth_o
);

   localparam logic [4:0] RaIdx = 5'(RA_REG);

   logic [StateW-1:0] state_d, state_q;
   logic [StateW-1:0] after_op;
   stack_op_t         op_q;
   logic              err_sticky_d, err_sticky_q;
   logic              accept;
   logic              full, empty;
   logic              cnt_inc, cnt_dec;

`ifdef STACK_SP_MIRROR_EN
   localparam logic [4:0] SpIdx = 5'(SP_REG);
   assign after_op = StSpWb;
`else
   logic unused_sp_params;
   assign unused_sp_params = ^{SP_REG, SP_BASE};
   assign after_op = StDone;
`endif

   assign accept     = op_valid_i && (state_q == StIdle);
   assign op_ready_o = (state_q == StIdle);
   assign cnt_inc    = (state_q == StPush) || (state_q == StCpush);
   assign cnt_dec    = (state_q == StPull);

   stack_depth_ctr #(
      .MaxCount (STACK_DEPTH),
      .Width    (DepthW)
   ) u_depth_ctr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (cnt_inc),
      .dec_i   (cnt_dec),
      .count_o (depth_o),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d      = state_q;
      err_sticky_d = err_sticky_q;
      case (state_q)
         StIdle: begin
            if (op_valid_i) begin
               unique case (op_code_i)
                  OP_PUSH: state_d = full ? StErr : StPush;
                  OP_CALL: state_d = full ? StErr : StSave;
                  OP_POP,
                  OP_RET:  state_d = empty ? StErr : StPull;
                  default: state_d = StIdle;
               endcase
               if (state_d == StErr) begin
                  err_sticky_d = 1'b1;
               end
            end
         end
         StPush:  state_d = after_op;
         StPull:  state_d = (op_q.code == OP_POP) ? StPopWb : StRetLd;
         StPopWb: state_d = after_op;
         StSave:  state_d = StCpush;
         StCpush: state_d = after_op;
         StRetLd: state_d = after_op;
         StSpWb:  state_d = StDone;
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         err_sticky_q <= 1'b0;
         op_q         <= '0;
      end else begin
         state_q      <= state_d;
         err_sticky_q <= err_sticky_d;
         if (accept) begin
            op_q <= '{code: op_code_i, rsel: op_reg_i, pc: pc_in_i, target: target_i};
         end
      end
   end

   // Decoded from the state register; stack data passes through since it is only valid
   // in the cycle after the pull strobe.
   always_comb begin
      read_reg1_o         = '0;
      write_reg_o         = '0;
      write_data_o        = '0;
      reg_write_control_o = 1'b0;
      pc_store_o          = 1'b0;
      push_stack_o        = 1'b0;
      pull_stack_o        = 1'b0;
      pc_load_o           = 1'b0;
      pc_next_o           = '0;
      done_o              = 1'b0;
      err_o               = 1'b0;
      case (state_q)
         StPush: begin
            read_reg1_o         = op_q.rsel;
            push_stack_o        = 1'b1;
            reg_write_control_o = 1'b1;
         end
         StPull: begin
            pull_stack_o        = 1'b1;
            reg_write_control_o = 1'b1;
         end
         StPopWb: begin
            write_reg_o         = op_q.rsel;
            write_data_o        = stack_data_i;
            reg_write_control_o = 1'b1;
         end
         StSave: begin
            pc_store_o          = 1'b1;
            reg_write_control_o = 1'b1;
            write_reg_o         = RaIdx;
            write_data_o        = op_q.pc + 32'd4;
         end
         StCpush: begin
            read_reg1_o         = RaIdx;
            push_stack_o        = 1'b1;
            reg_write_control_o = 1'b1;
         end
         StRetLd: begin
            pc_load_o = 1'b1;
            pc_next_o = stack_data_i;
         end
`ifdef STACK_SP_MIRROR_EN
         StSpWb: begin
            write_reg_o         = SpIdx;
            write_data_o        = SP_BASE - (32'(depth_o) << 2);
            reg_write_control_o = 1'b1;
         end
`endif
         StDone: begin
            done_o = 1'b1;
            if (op_q.code == OP_CALL) begin
               pc_load_o = 1'b1;
               pc_next_o = op_q.target;
            end
         end
         StErr: begin
            err_o  = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign err_sticky_o = err_sticky_q;

endmodule
